// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot decoder pipeline: FSM state
// encoding, drop counter width and the binary-to-one-hot decode function.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int DROP_CNT_W = 8;

  // Widest code the decode helper supports; callers cast down to their N.
  localparam int DEC_MAX_W = 8;
  localparam int DEC_MAX_N = 2 ** DEC_MAX_W;

  // if/else per bit so an unknown code decodes to zeros rather than X
  function automatic logic [DEC_MAX_N-1:0] decode(input logic [DEC_MAX_W-1:0] code);
    logic [DEC_MAX_N-1:0] word;
    word = {DEC_MAX_N{1'b0}};
    for (int i = 0; i < DEC_MAX_N; i++) begin
      if (code == DEC_MAX_W'(i)) begin
        word[i] = 1'b1;
      end else begin
        word[i] = 1'b0;
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic N-bit two-entry valid/ready skid buffer. The main register drives
// the outputs; the skid register catches the word accepted under backpressure.
module dec_skid_buf
  import onehot_dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  state_t       state_r, state_nxt_s;
  logic [N-1:0] main_r, main_nxt_s;
  logic [N-1:0] skid_r, skid_nxt_s;
  logic         out_valid_r;
  logic         accept_s, xfer_s;

  // ready depends on state only, never on out_ready
  assign in_ready  = !rst && (state_r != TWO);
  assign accept_s  = in_valid && in_ready;
  assign xfer_s    = out_valid_r && out_ready;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

  // Next-state and storage steering for the EMPTY/ONE/TWO occupancy FSM
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ONE;
          main_nxt_s  = in_data;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && !xfer_s) begin
          state_nxt_s = TWO;
          skid_nxt_s  = in_data;
        end else if (accept_s && xfer_s) begin
          state_nxt_s = ONE;
          main_nxt_s  = in_data;
        end else if (xfer_s) begin
          state_nxt_s = EMPTY;
          main_nxt_s  = {N{1'b0}};
        end else begin
          state_nxt_s = ONE;
        end
      end
      TWO: begin
        if (xfer_s) begin
          state_nxt_s = ONE;
          main_nxt_s  = skid_r;
          skid_nxt_s  = {N{1'b0}};
        end else begin
          state_nxt_s = TWO;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        main_nxt_s  = {N{1'b0}};
        skid_nxt_s  = {N{1'b0}};
      end
    endcase
  end

  // State and data registers; reset clears both entries immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= {N{1'b0}};
      skid_r      <= {N{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready skid buffering.
// Define DEC_ZERO_PASS_EN to pass in_vbit=0 words downstream as all-zero words.
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter int W = 2,
  localparam int N = 2 ** W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_vbit,
  input  logic [W-1:0]          in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_onehot,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [N-1:0]          onehot_s;
  logic [N-1:0]          store_s;
  logic                  buf_valid_s;
  logic                  drop_s;
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  assign onehot_s = N'(decode(DEC_MAX_W'(in_code)));

  // Filter words without an active request line before they reach storage
  always_comb begin
    store_s     = {N{1'b0}};
    buf_valid_s = 1'b0;
    drop_s      = 1'b0;
`ifdef DEC_ZERO_PASS_EN
    buf_valid_s = in_valid;
    if (in_vbit) begin
      store_s = onehot_s;
    end else begin
      store_s = {N{1'b0}};
    end
`else
    buf_valid_s = in_valid && in_vbit;
    drop_s      = in_valid && in_ready && !in_vbit;
    store_s     = onehot_s;
`endif
  end

  dec_skid_buf #(
    .N (N)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (buf_valid_s),
    .in_ready  (in_ready),
    .in_data   (store_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_onehot)
  );

  // Saturating count of consumed-but-discarded words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Directed bench for onehot_decoder_pipe (W=2 and W=3 instances); expectations
// follow DEC_ZERO_PASS_EN when the bench is built with it.
module tb_onehot_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_vbit, out_ready;
  logic [1:0] in_code;
  logic       in_ready, out_valid;
  logic [3:0] out_onehot;
  logic [7:0] drop_cnt;

  logic       d3_in_valid, d3_in_vbit, d3_out_ready;
  logic [2:0] d3_in_code;
  logic       d3_in_ready, d3_out_valid;
  logic [7:0] d3_out_onehot;
  logic [7:0] d3_drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vbit(in_vbit), .in_code(in_code), .out_valid(out_valid),
    .out_ready(out_ready), .out_onehot(out_onehot), .drop_cnt(drop_cnt)
  );

  onehot_decoder_pipe #(.W(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_vbit(d3_in_vbit), .in_code(d3_in_code), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .out_onehot(d3_out_onehot), .drop_cnt(d3_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_vbit = 1'b0; in_code = 2'd0; out_ready = 1'b0;
    d3_in_valid = 1'b0; d3_in_vbit = 1'b0; d3_in_code = 3'd0; d3_out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_onehot", 32'(out_onehot), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // stream codes 0..3 with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1; in_vbit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = 2'(i);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_onehot", 32'(out_onehot), 32'd1 << i);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("stream_drain_onehot", 32'(out_onehot), 32'd0);

    // backpressure: fill both entries, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd2;
    step();
    chk("bp_one_onehot", 32'(out_onehot), 32'h4);
    chk("bp_one_ready", 32'(in_ready), 32'd1);
    in_code = 2'd1;
    step();
    chk("bp_two_onehot", 32'(out_onehot), 32'h4);
    chk("bp_two_ready", 32'(in_ready), 32'd0);
    in_code = 2'd3;
    step();
    chk("bp_hold_onehot", 32'(out_onehot), 32'h4);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_drain1_onehot", 32'(out_onehot), 32'h2);
    chk("bp_drain1_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_drain2_valid", 32'(out_valid), 32'd0);
    chk("bp_drain2_onehot", 32'(out_onehot), 32'd0);

    // simultaneous accept and transfer in ONE
    out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd0;
    step();
    chk("sim_first", 32'(out_onehot), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_code = 2'((i + 1) % 4);
      step();
      chk("sim_onehot", 32'(out_onehot), 32'd1 << ((i + 1) % 4));
      chk("sim_valid", 32'(out_valid), 32'd1);
      chk("sim_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("sim_drain_valid", 32'(out_valid), 32'd0);

    // words with in_vbit=0
    in_valid = 1'b1; in_vbit = 1'b0; in_code = 2'd3;
    for (int i = 0; i < 300; i++) begin
      step();
`ifdef DEC_ZERO_PASS_EN
      chk("vbit0_valid", 32'(out_valid), 32'd1);
      chk("vbit0_onehot", 32'(out_onehot), 32'd0);
`else
      chk("vbit0_valid", 32'(out_valid), 32'd0);
      chk("vbit0_ready", 32'(in_ready), 32'd1);
      if (i == 9) chk("vbit0_cnt10", 32'(drop_cnt), 32'd10);
`endif
    end
`ifdef DEC_ZERO_PASS_EN
    chk("vbit0_drop_cnt", 32'(drop_cnt), 32'd0);
`else
    chk("vbit0_drop_cnt", 32'(drop_cnt), 32'd255);
`endif
    in_valid = 1'b0; in_vbit = 1'b1;
    step();
    chk("vbit0_drain", 32'(out_valid), 32'd0);

    // reset while in TWO clears outputs without an edge
    out_ready = 1'b0; in_valid = 1'b1; in_code = 2'd1;
    step();
    in_code = 2'd2;
    step();
    chk("two_ready", 32'(in_ready), 32'd0);
    chk("two_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_onehot", 32'(out_onehot), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    chk("async_rst_drop", 32'(drop_cnt), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_code = 2'd3; out_ready = 1'b1;
    step();
    chk("after_rst_onehot", 32'(out_onehot), 32'h8);
    in_valid = 1'b0;
    step();
    chk("after_rst_skid_empty", 32'(out_valid), 32'd0);

    // W=3 instance
    d3_out_ready = 1'b1; d3_in_valid = 1'b1; d3_in_vbit = 1'b1; d3_in_code = 3'd5;
    step();
    chk("w3_code5", 32'(d3_out_onehot), 32'h20);
    chk("w3_valid", 32'(d3_out_valid), 32'd1);
    d3_in_code = 3'd7;
    step();
    chk("w3_code7", 32'(d3_out_onehot), 32'h80);
    d3_in_valid = 1'b0;
    step();
    chk("w3_drain", 32'(d3_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_pipe.md
# onehot_decoder_pipe

Registered binary-to-one-hot decoder with valid/ready flow control. It is the receive-side counterpart of the 4-to-2 priority encoder: it takes the encoder's index and valid bit, and drives a one-hot request word to a downstream consumer. A two-entry skid buffer lets upstream stream one code per cycle while absorbing one cycle of downstream backpressure without a combinational ready path.

## Interface
- W, default 2, code width; the one-hot output is N = 2**W bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_vbit  input  1  encoder valid bit (0 = no active request line).
- in_code  input  W  encoded index, meaningful only when in_vbit=1.
- out_valid  output  1  out_onehot holds a word.
- out_ready  input  1  downstream accepts the word.
- out_onehot  output  N  decoded word, bit in_code set.
- drop_cnt  output  8  saturating count of words discarded because in_vbit=0.

## Operation
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- Decode happens at the input, before storage. Entries hold N-bit one-hot words, not codes.
- Decode rule: onehot[i] = (in_code == i). Exactly one bit is set when in_vbit=1. in_code values X or Z are never stored as X.
- States: EMPTY, ONE, TWO. The main register drives the outputs; the skid register holds the second word.
- EMPTY:
  - accept -> ONE; the word goes to main.
- ONE:
  - accept with no transfer -> TWO; the word goes to skid.
  - accept with transfer -> ONE; main is replaced by the new word.
  - transfer with no accept -> EMPTY.
  - otherwise hold.
- TWO:
  - transfer -> ONE; skid moves to main.
  - no accept is possible in TWO.
- in_ready = !rst && (state != TWO). This is combinational from state only and never depends on out_ready.
- Words with in_vbit=0 are handled per Configuration.
- drop_cnt increments by 1 on each dropped accept and saturates at 255. It never wraps.

## Timing
- Latency: a word accepted on edge k appears on out_onehot/out_valid after edge k. Out_valid is high in the cycle following acceptance.
- Throughput: 1 word/cycle when out_ready is held high.
- Outputs stay stable while out_valid=1 and out_ready=0.
- out_valid=0 implies out_onehot=0.
- Reset values: state EMPTY, out_valid 0, out_onehot 0, drop_cnt 0, skid 0. in_ready is 0 while rst is high and 1 from the first cycle after release.
- Reset mid-operation discards both stored words immediately, without waiting for an edge. No partial transfer is reported.
- Simultaneous accept and transfer in ONE preserves order. The old word leaves and the new word becomes main.

## Configuration
- Macro: DEC_ZERO_PASS_EN.
- Defined: an accepted word with in_vbit=0 is stored as an all-zero out_onehot with out_valid=1, passing "no request" downstream. drop_cnt stays 0.
- Undefined: an accepted word with in_vbit=0 is consumed (in_ready behaves as usual) and never stored. State is unchanged and drop_cnt increments.

## Structure
- Package onehot_dec_pkg:
  - state enum (EMPTY, ONE, TWO).
  - DROP_CNT_W = 8 constant.
  - decode function taking a W-bit code and returning an N-bit one-hot word.
- Sub-module dec_skid_buf: a generic N-bit two-entry valid/ready skid buffer holding the state machine.
- The top level contains the decode logic, the vbit filter and drop_cnt.

## Test plan
- Reset then stream, W=2, out_ready=1: codes 0,1,2,3 with vbit=1 on consecutive cycles -> out_onehot 0001,0010,0100,1000 on consecutive cycles, one cycle after each accept.
- Backpressure: accept code 2, hold out_ready=0, accept code 1 -> in_ready drops to 0. Raise out_ready -> 0100 then 0010, no loss or duplication.
- Simultaneous accept and transfer in ONE for 10 cycles -> in_ready stays 1 and out_valid stays 1 with correct order.
- vbit=0 words:
  - Macro undefined, 300 words -> no out_valid, drop_cnt = 255.
  - Macro defined -> out_onehot 0000 with out_valid=1.
- Assert rst while in TWO -> out_valid and out_onehot read 0 immediately. After release, the first accepted code 3 -> 1000.
- W=3: code 5 -> out_onehot 00100000.
